ram_arbiter: RTL

- Shares the single-port, word-addressed 16-bit RAM between two requesters.
- Port 0 is the CPU memory interface; port 1 is the program loader/debug path.
- Arbitration is round-robin, with an optional locked burst per port so one master can stream an array or program image without interruption.
- Sits between the masters and the RAM. The RAM has synchronous write and a 1-cycle registered read, and the block tracks that read latency.

---
 rtl/albacore_mem_pkg.sv | 30 +++
 rtl/ram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/albacore_mem_pkg.sv
// Shared definitions for the albacore memory subsystem: widths, owner encoding,
// port identifiers and small helpers used by the RAM arbiter.
package albacore_mem_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Counter width able to hold 0..max_burst; an unlimited burst still needs one bit.
   function automatic int burst_width(input int max_burst);
      return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
   endfunction

   function automatic owner_t owner_of(input logic port);
      return (port == PORT1) ? OWN_P1 : OWN_P0;
   endfunction

   function automatic logic [1:0] port_mask(input logic port);
      return (port == PORT1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM, with
// optional locked bursts and routing of the 1-cycle registered read data.
module ram_arbiter
   import albacore_mem_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MAX_BURST = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_ack,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_ack,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   localparam int            BW        = burst_width(MAX_BURST);
   localparam bit            LIMIT_ON  = (MAX_BURST != 0);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   owner_t        owner_r, owner_nx_s;
   logic          rr_last_r, rr_last_nx_s;
   logic [BW-1:0] burst_cnt_r, burst_cnt_nx_s, burst_inc_s;
   // A port whose burst hit the limit may not relock until it drops lock once.
   logic [1:0]    relock_blk_r, relock_blk_nx_s;
   logic          tag_valid_r, tag_valid_nx_s;
   logic          tag_port_r, tag_port_nx_s;

   logic          win_valid_s, win_port_s, win_we_s, win_lock_s, win_blk_s;
   logic          own_lock_s, limit_hit_s;

   assign win_we_s    = (win_port_s == PORT1) ? m1_we : m0_we;
   assign win_lock_s  = (win_port_s == PORT1) ? m1_lock : m0_lock;
   assign win_blk_s   = (win_port_s == PORT1) ? relock_blk_r[1] : relock_blk_r[0];
   assign own_lock_s  = (owner_r == OWN_P1) ? m1_lock : m0_lock;
   assign burst_inc_s = burst_cnt_r + BW'(1'b1);
   assign limit_hit_s = LIMIT_ON && (burst_inc_s == BURST_MAX);

   // Grant decision for the current cycle from requests, owner and round-robin pointer.
   always_comb begin
      win_valid_s = 1'b0;
      win_port_s  = PORT0;
      if (reset) begin
         win_valid_s = 1'b0;
         win_port_s  = PORT0;
      end else begin
         case (owner_r)
            OWN_P0: begin
               win_valid_s = m0_req;
               win_port_s  = PORT0;
            end
            OWN_P1: begin
               win_valid_s = m1_req;
               win_port_s  = PORT1;
            end
            default: begin
               if (m0_req && m1_req) begin
                  win_valid_s = 1'b1;
                  win_port_s  = ~rr_last_r;
               end else if (m0_req) begin
                  win_valid_s = 1'b1;
                  win_port_s  = PORT0;
               end else if (m1_req) begin
                  win_valid_s = 1'b1;
                  win_port_s  = PORT1;
               end else begin
                  win_valid_s = 1'b0;
                  win_port_s  = PORT0;
               end
            end
         endcase
      end
   end

   // Next ownership, burst count, round-robin pointer and read tag.
   always_comb begin
      owner_nx_s      = owner_r;
      burst_cnt_nx_s  = burst_cnt_r;
      relock_blk_nx_s = relock_blk_r & {m1_lock, m0_lock};
      rr_last_nx_s    = win_valid_s ? win_port_s : rr_last_r;
      tag_valid_nx_s  = win_valid_s & ~win_we_s;
      tag_port_nx_s   = win_port_s;
      case (owner_r)
         OWN_P0, OWN_P1: begin
            if (!own_lock_s) begin
               owner_nx_s     = OWN_NONE;
               burst_cnt_nx_s = {BW{1'b0}};
            end else if (win_valid_s && limit_hit_s) begin
               owner_nx_s      = OWN_NONE;
               burst_cnt_nx_s  = {BW{1'b0}};
               relock_blk_nx_s = relock_blk_nx_s | port_mask(win_port_s);
            end else if (win_valid_s) begin
               burst_cnt_nx_s = burst_inc_s;
            end else begin
               burst_cnt_nx_s = burst_cnt_r;
            end
         end
         default: begin
            if (win_valid_s && win_lock_s && !win_blk_s) begin
               if (limit_hit_s) begin
                  owner_nx_s      = OWN_NONE;
                  burst_cnt_nx_s  = {BW{1'b0}};
                  relock_blk_nx_s = relock_blk_nx_s | port_mask(win_port_s);
               end else begin
                  owner_nx_s     = owner_of(win_port_s);
                  burst_cnt_nx_s = burst_inc_s;
               end
            end else begin
               owner_nx_s     = OWN_NONE;
               burst_cnt_nx_s = {BW{1'b0}};
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_r      <= OWN_NONE;
         rr_last_r    <= PORT1;
         burst_cnt_r  <= {BW{1'b0}};
         relock_blk_r <= 2'b00;
         tag_valid_r  <= 1'b0;
         tag_port_r   <= PORT0;
      end else begin
         owner_r      <= owner_nx_s;
         rr_last_r    <= rr_last_nx_s;
         burst_cnt_r  <= burst_cnt_nx_s;
         relock_blk_r <= relock_blk_nx_s;
         tag_valid_r  <= tag_valid_nx_s;
         tag_port_r   <= tag_port_nx_s;
      end
   end

   // Acks and RAM command; port 0's command is parked on the bus when idle.
   always_comb begin
      m0_ack = win_valid_s & (win_port_s == PORT0);
      m1_ack = win_valid_s & (win_port_s == PORT1);
      ram_we = win_valid_s & win_we_s;
      if (win_valid_s && (win_port_s == PORT1)) begin
         ram_addr = m1_addr;
         ram_din  = m1_wdata;
      end else begin
         ram_addr = m0_addr;
         ram_din  = m0_wdata;
      end
   end

   assign m0_rvalid = tag_valid_r & (tag_port_r == PORT0);
   assign m1_rvalid = tag_valid_r & (tag_port_r == PORT1);
   assign m0_rdata  = ram_dout;
   assign m1_rdata  = ram_dout;

endmodule
